instr_window_seq: RTL and testbench

Sequencer that feeds the instruction identification stage. It accepts a stream of 32-bit instruction words from fetch and buffers them. Each issued window is 64 bits and holds either one word or a prefix+suffix pair. It tracks the instruction address, flags prefixed instructions that cross a 64-byte boundary, and stalls on fault until redirected.

---
 rtl/instr_window_pkg.sv | 25 ++
 rtl/instr_window_chk.sv | 28 ++
 rtl/word_fifo.sv | 63 ++++++
 rtl/instr_window_seq.sv | 182 ++++++++++++++++++
 tb/tb_instr_window_seq.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_window_pkg.sv
// Shared types and helpers for the instruction window sequencer.
// Prefix detection lives here so every consumer agrees on the opcode.
package instr_window_pkg;

  localparam int ADDR_W = 64;
  localparam logic [5:0] PREFIX_OPCODE = 6'b100000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } seq_state_t;

  // What the head of the buffer (plus the word arriving now) can issue.
  typedef enum logic [1:0] {
    WIN_NONE   = 2'd0,
    WIN_SINGLE = 2'd1,
    WIN_PAIR   = 2'd2,
    WIN_FAULT  = 2'd3
  } win_kind_t;

  function automatic logic is_prefix(input logic [31:0] word);
    return (word[5:0] == PREFIX_OPCODE);
  endfunction

endpackage

// File: rtl/instr_window_chk.sv
// Invariants of the sequencer's issue interface and buffer occupancy.
module instr_window_chk #(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input logic             clk,
  input logic             rst,
  input logic             redirect,
  input logic             id_ready,
  input logic             id_en,
  input logic [63:0]      id_instr,
  input logic [63:0]      id_addr,
  input logic             id_prefixed,
  input logic             align_fault,
  input logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= DEPTH_CNT);

  a_fault_is_prefix: assert property (@(posedge clk) disable iff (rst)
    align_fault |-> id_prefixed);

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (id_en && !id_ready && !redirect) |=> (id_en && $stable(id_instr) && $stable(id_addr)));

endmodule

// File: rtl/word_fifo.sv
// Circular word buffer with single push and pop of one or two entries.
// A pop may consume the word being pushed in the same cycle.
module word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_one,
  input  logic             pop_two,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] head_next,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] pop_cnt;

  // Number of entries leaving the buffer this cycle.
  always_comb begin
    pop_cnt = '0;
    if (pop_two) begin
      pop_cnt = CNT_W'(2);
    end else if (pop_one) begin
      pop_cnt = CNT_W'(1);
    end else begin
      pop_cnt = '0;
    end
  end

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap freely.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr <= rd_ptr + pop_cnt[PTR_W-1:0];
      count  <= count + CNT_W'(push) - pop_cnt;
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign head      = mem[rd_ptr];
  assign head_next = mem[rd_ptr + PTR_W'(1)];

endmodule

// File: rtl/instr_window_seq.sv
// Instruction window sequencer: buffers fetch words and issues 64-bit windows
// (single word or prefix+suffix) with address tracking and boundary-fault halt.
module instr_window_seq
  import instr_window_pkg::*;
#(
  parameter int          DEPTH      = 4,
  parameter logic [63:0] RESET_ADDR = 64'h0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_word_valid,
  input  logic [31:0] i_word,
  output logic        o_word_ready,
  input  logic        i_redirect,
  input  logic [63:0] i_redirect_addr,
  output logic        o_id_en,
  output logic [63:0] o_id_instr,
  output logic [63:0] o_id_addr,
  output logic        o_id_prefixed,
  output logic        o_align_fault,
  input  logic        i_id_ready
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO_CNT   = CNT_W'(2);

  seq_state_t         state;
  seq_state_t         state_next;
  win_kind_t          kind;
  logic [ADDR_W-1:0]  addr;
  logic [CNT_W-1:0]   count;
  logic [31:0]        fifo_head;
  logic [31:0]        fifo_next;
  logic [31:0]        win_head;
  logic [31:0]        win_next;
  logic               push;
  logic               pop_one;
  logic               pop_two;
  logic               has_one;
  logic               has_two;
  logic               out_free;
  logic               load;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^i_redirect_addr[1:0];

  assign o_word_ready = (count < DEPTH_CNT) && (state == RUN) && !i_redirect;
  assign push         = i_word_valid && o_word_ready;
  assign out_free     = !o_id_en || i_id_ready;

  word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .clr       (i_redirect),
    .push      (push),
    .push_data (i_word),
    .pop_one   (pop_one),
    .pop_two   (pop_two),
    .head      (fifo_head),
    .head_next (fifo_next),
    .count     (count)
  );

  // Window view includes the word arriving this cycle, so an empty buffer adds no latency.
  always_comb begin
    has_one  = (count != '0) || push;
    has_two  = (count >= TWO_CNT) || ((count == ONE_CNT) && push);
    win_head = (count != '0) ? fifo_head : i_word;
    win_next = (count >= TWO_CNT) ? fifo_next : i_word;
    kind     = WIN_NONE;
    if (!has_one) begin
      kind = WIN_NONE;
    end else if (!is_prefix(win_head)) begin
      kind = WIN_SINGLE;
    end else if (addr[5:2] == 4'hF) begin
      kind = WIN_FAULT;
    end else if (has_two) begin
      kind = WIN_PAIR;
    end else begin
      kind = WIN_NONE;
    end
  end

  // Sequencer state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state and load/pop decisions.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      RUN: begin
        if (i_redirect) begin
          state_next = RUN;
        end else if (out_free && (kind != WIN_NONE)) begin
          load       = 1'b1;
          state_next = (kind == WIN_FAULT) ? HALT : RUN;
        end else begin
          state_next = RUN;
        end
      end
      HALT: begin
        if (i_redirect) begin
          state_next = RUN;
        end else begin
          state_next = HALT;
        end
      end
      default: begin
        state_next = RUN;
      end
    endcase
    pop_one = load && ((kind == WIN_SINGLE) || (kind == WIN_FAULT));
    pop_two = load && (kind == WIN_PAIR);
  end

  // Address counter and issue register; a redirect drops any held window.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr          <= RESET_ADDR;
      o_id_en       <= 1'b0;
      o_id_instr    <= 64'h0;
      o_id_addr     <= RESET_ADDR;
      o_id_prefixed <= 1'b0;
      o_align_fault <= 1'b0;
    end else if (i_redirect) begin
      addr      <= {i_redirect_addr[63:2], 2'b00};
      o_id_en   <= 1'b0;
      o_id_addr <= {i_redirect_addr[63:2], 2'b00};
    end else if (load) begin
      o_id_en       <= 1'b1;
      o_id_addr     <= addr;
      o_id_prefixed <= (kind != WIN_SINGLE);
      o_align_fault <= (kind == WIN_FAULT);
      case (kind)
        WIN_SINGLE: begin
          o_id_instr <= {32'h0, win_head};
          addr       <= addr + 64'd4;
        end
        WIN_PAIR: begin
          o_id_instr <= {win_next, win_head};
          addr       <= addr + 64'd8;
        end
        WIN_FAULT: begin
          o_id_instr <= {32'h0, win_head};
        end
        default: begin
          o_id_instr <= o_id_instr;
        end
      endcase
    end else if (i_id_ready) begin
      o_id_en <= 1'b0;
    end
  end

  instr_window_chk #(
    .DEPTH (DEPTH)
  ) u_chk (
    .clk         (i_clk),
    .rst         (i_rst),
    .redirect    (i_redirect),
    .id_ready    (i_id_ready),
    .id_en       (o_id_en),
    .id_instr    (o_id_instr),
    .id_addr     (o_id_addr),
    .id_prefixed (o_id_prefixed),
    .align_fault (o_align_fault),
    .count       (count)
  );

endmodule

// File: tb/tb_instr_window_seq.sv
// Directed checks of instr_window_seq plus a randomized valid/ready run
// compared against a behavioural window model.
module tb_instr_window_seq;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_word_valid;
  logic [31:0] i_word;
  logic        o_word_ready;
  logic        i_redirect;
  logic [63:0] i_redirect_addr;
  logic        o_id_en;
  logic [63:0] o_id_instr;
  logic [63:0] o_id_addr;
  logic        o_id_prefixed;
  logic        o_align_fault;
  logic        i_id_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_window_seq #(
    .DEPTH      (4),
    .RESET_ADDR (64'h1000)
  ) dut (
    .i_clk           (clk),
    .i_rst           (i_rst),
    .i_word_valid    (i_word_valid),
    .i_word          (i_word),
    .o_word_ready    (o_word_ready),
    .i_redirect      (i_redirect),
    .i_redirect_addr (i_redirect_addr),
    .o_id_en         (o_id_en),
    .o_id_instr      (o_id_instr),
    .o_id_addr       (o_id_addr),
    .o_id_prefixed   (o_id_prefixed),
    .o_align_fault   (o_align_fault),
    .i_id_ready      (i_id_ready)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_win(input string tag, input logic [63:0] instr, input logic [63:0] addr,
                           input logic pref, input logic fault);
    check_val({tag, ".en"}, {63'h0, o_id_en}, 64'd1);
    check_val({tag, ".instr"}, o_id_instr, instr);
    check_val({tag, ".addr"}, o_id_addr, addr);
    check_val({tag, ".pref"}, {63'h0, o_id_prefixed}, {63'h0, pref});
    check_val({tag, ".fault"}, {63'h0, o_align_fault}, {63'h0, fault});
  endtask

  task automatic redirect_to(input logic [63:0] a);
    i_redirect      = 1'b1;
    i_redirect_addr = a;
    i_word_valid    = 1'b0;
    tick();
    i_redirect      = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q[$];
    logic [63:0] maddr;
    logic [63:0] redir_tgt;
    logic [63:0] e_instr;
    logic [31:0] h;
    logic [31:0] s;
    logic [31:0] w;
    logic        e_pref;
    logic        e_fault;
    logic        pend_redir;
    int          npop;
    int          step;
    int          pushed;
    int          cyc;

    i_rst           = 1'b1;
    i_word_valid    = 1'b0;
    i_word          = 32'h0;
    i_redirect      = 1'b0;
    i_redirect_addr = 64'h0;
    i_id_ready      = 1'b1;
    repeat (3) tick();
    i_rst = 1'b0;
    settle();
    check_val("rst.en", {63'h0, o_id_en}, 64'd0);
    check_val("rst.instr", o_id_instr, 64'h0);
    check_val("rst.addr", o_id_addr, 64'h1000);
    check_val("rst.pref", {63'h0, o_id_prefixed}, 64'd0);
    check_val("rst.fault", {63'h0, o_align_fault}, 64'd0);
    check_val("rst.ready", {63'h0, o_word_ready}, 64'd1);

    // Two plain words back to back, one-cycle latency each
    i_word_valid = 1'b1;
    i_word       = 32'h38;
    tick();
    i_word = 32'h3C;
    settle();
    check_win("t1.w0", 64'h38, 64'h1000, 1'b0, 1'b0);
    tick();
    i_word_valid = 1'b0;
    settle();
    check_win("t1.w1", 64'h3C, 64'h1004, 1'b0, 1'b0);
    tick();
    settle();
    check_val("t1.drain", {63'h0, o_id_en}, 64'd0);

    // Prefix, three idle cycles, then suffix
    redirect_to(64'h2000);
    i_word_valid = 1'b1;
    i_word       = 32'h20;
    tick();
    i_word_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_val("t2.gap", {63'h0, o_id_en}, 64'd0);
      tick();
    end
    i_word_valid = 1'b1;
    i_word       = 32'hDEADBEEC;
    tick();
    i_word = 32'h38;
    settle();
    check_win("t2.pair", 64'hDEADBEEC_00000020, 64'h2000, 1'b1, 1'b0);
    tick();
    i_word_valid = 1'b0;
    settle();
    check_win("t2.next", 64'h38, 64'h2008, 1'b0, 1'b0);

    // Prefix in the last slot of a 64-byte line faults and halts
    redirect_to(64'h103C);
    i_word_valid = 1'b1;
    i_word       = 32'h20;
    tick();
    i_word_valid = 1'b0;
    i_id_ready   = 1'b0;
    settle();
    check_win("t3.fault", 64'h20, 64'h103C, 1'b1, 1'b1);
    check_val("t3.rdy0", {63'h0, o_word_ready}, 64'd0);
    tick();
    settle();
    check_win("t3.hold", 64'h20, 64'h103C, 1'b1, 1'b1);
    i_id_ready = 1'b1;
    tick();
    settle();
    check_val("t3.consumed", {63'h0, o_id_en}, 64'd0);
    i_word_valid = 1'b1;
    i_word       = 32'h38;
    settle();
    check_val("t3.rdy1", {63'h0, o_word_ready}, 64'd0);
    tick();
    settle();
    check_val("t3.noacc", {63'h0, o_id_en}, 64'd0);
    redirect_to(64'h4000);
    i_word_valid = 1'b1;
    i_word       = 32'h44;
    settle();
    check_val("t3.rdy2", {63'h0, o_word_ready}, 64'd1);
    tick();
    i_word_valid = 1'b0;
    settle();
    check_win("t3.resume", 64'h44, 64'h4000, 1'b0, 1'b0);

    // Backpressure: one held window plus DEPTH buffered words
    redirect_to(64'h5000);
    i_id_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      i_word_valid = 1'b1;
      i_word       = 32'hA000_0001 + 32'(k * 64);
      settle();
      check_val($sformatf("t4.rdy%0d", k), {63'h0, o_word_ready}, (k < 5) ? 64'd1 : 64'd0);
      tick();
    end
    i_word_valid = 1'b0;
    i_id_ready   = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle();
      check_win($sformatf("t4.drain%0d", k), {32'h0, 32'hA000_0001 + 32'(k * 64)},
                64'h5000 + 64'(k * 4), 1'b0, 1'b0);
      tick();
    end
    settle();
    check_val("t4.empty", {63'h0, o_id_en}, 64'd0);

    // Redirect beats a consuming handshake and a presented word
    redirect_to(64'h6000);
    i_id_ready   = 1'b0;
    i_word_valid = 1'b1;
    i_word       = 32'h40;
    tick();
    i_word = 32'h80;
    tick();
    i_redirect      = 1'b1;
    i_redirect_addr = 64'h7000;
    i_id_ready      = 1'b1;
    i_word          = 32'hC0;
    settle();
    check_val("t5.rdy", {63'h0, o_word_ready}, 64'd0);
    tick();
    i_redirect   = 1'b0;
    i_word_valid = 1'b0;
    settle();
    check_val("t5.en0", {63'h0, o_id_en}, 64'd0);
    tick();
    settle();
    check_val("t5.en1", {63'h0, o_id_en}, 64'd0);
    i_word_valid = 1'b1;
    i_word       = 32'h104;
    tick();
    i_word_valid = 1'b0;
    settle();
    check_win("t5.target", 64'h104, 64'h7000, 1'b0, 1'b0);

    // Address wraps at 2^64; low redirect bits ignored
    redirect_to(64'hFFFF_FFFF_FFFF_FFF9);
    i_word_valid = 1'b1;
    i_word       = 32'h1;
    tick();
    i_word = 32'h2;
    settle();
    check_win("t6.w0", 64'h1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0);
    tick();
    i_word = 32'h3;
    settle();
    check_win("t6.w1", 64'h2, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0);
    tick();
    i_word_valid = 1'b0;
    settle();
    check_win("t6.wrap", 64'h3, 64'h0, 1'b0, 1'b0);

    // Prefix in slot 0xE pairs normally and ends on the line boundary
    redirect_to(64'h8038);
    i_word_valid = 1'b1;
    i_word       = 32'h20;
    tick();
    i_word = 32'h55;
    tick();
    i_word = 32'h4;
    settle();
    check_win("t7.pair", 64'h00000055_00000020, 64'h8038, 1'b1, 1'b0);
    tick();
    i_word_valid = 1'b0;
    settle();
    check_win("t7.next", 64'h4, 64'h8040, 1'b0, 1'b0);

    // Randomized valid/ready against a window model
    redirect_to(64'h9000);
    maddr      = 64'h9000;
    pend_redir = 1'b0;
    redir_tgt  = 64'h0;
    pushed     = 0;
    cyc        = 0;
    while (pushed < 10000 && cyc < 60000) begin
      cyc++;
      i_redirect      = pend_redir;
      i_redirect_addr = redir_tgt;
      i_word_valid    = ($urandom_range(3) != 0);
      w = $urandom;
      if ($urandom_range(7) == 0) begin
        w[5:0] = 6'h20;
      end else if (w[5:0] == 6'h20) begin
        w[5:0] = 6'h21;
      end
      i_word     = w;
      i_id_ready = ($urandom_range(3) != 0);
      settle();
      if (i_redirect) begin
        q.delete();
        maddr      = {redir_tgt[63:2], 2'b00};
        pend_redir = 1'b0;
      end else begin
        if (o_id_en && i_id_ready) begin
          h = (q.size() > 0) ? q[0] : 32'h0;
          s = (q.size() > 1) ? q[1] : 32'h0;
          if (h[5:0] != 6'h20) begin
            e_instr = {32'h0, h};
            e_pref  = 1'b0;
            e_fault = 1'b0;
            npop    = 1;
            step    = 4;
          end else if (maddr[5:2] == 4'hF) begin
            e_instr    = {32'h0, h};
            e_pref     = 1'b1;
            e_fault    = 1'b1;
            npop       = 1;
            step       = 0;
            pend_redir = 1'b1;
            redir_tgt  = {$urandom, $urandom};
          end else begin
            e_instr = {s, h};
            e_pref  = 1'b1;
            e_fault = 1'b0;
            npop    = 2;
            step    = 8;
          end
          check_val("rand.avail", 64'(q.size() >= npop), 64'd1);
          check_val("rand.instr", o_id_instr, e_instr);
          check_val("rand.addr", o_id_addr, maddr);
          check_val("rand.pref", {63'h0, o_id_prefixed}, {63'h0, e_pref});
          check_val("rand.fault", {63'h0, o_align_fault}, {63'h0, e_fault});
          for (int j = 0; j < npop; j++) begin
            if (q.size() > 0) begin
              void'(q.pop_front());
            end
          end
          maddr = maddr + 64'(step);
        end
        if (i_word_valid && o_word_ready) begin
          q.push_back(i_word);
          pushed++;
        end
      end
      tick();
    end
    i_redirect   = 1'b0;
    i_word_valid = 1'b0;
    check_val("rand.budget", 64'(pushed >= 10000), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
